// File: rtl/grid_traffic_gen.sv
// Per-node synthetic packet injector: random-driven generation into a small queue toward the router port.
// Latency: an accepted attempt reaches the queue head one cycle later; a full queue drops new attempts and holds the head until out_ready.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end
endmodule

module grid_traffic_gen #(
  parameter int X_BITS     = 2,
  parameter int Y_BITS     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int RAND_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [RAND_WIDTH-1:0] rand_vect,
  input  logic                  enable,
  input  logic [7:0]            inj_rate,
  input  logic [15:0]           pkt_limit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [X_BITS-1:0]     out_dest_x,
  output logic [Y_BITS-1:0]     out_dest_y,
  output logic [7:0]            out_seq,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           gen_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  done
);
  typedef struct packed {
    logic [X_BITS-1:0]     dest_x;
    logic [Y_BITS-1:0]     dest_y;
    logic [7:0]            seq;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [X_BITS-1:0] SELF_X = MY_X[X_BITS-1:0];
  localparam logic [Y_BITS-1:0] SELF_Y = MY_Y[Y_BITS-1:0];
  localparam logic [X_BITS-1:0] ALT_X  = SELF_X + 1'b1;

  state_t            state;
  state_t            next_state;
  logic              start_run;
  logic [7:0]        seq;
  pkt_t              cand;
  pkt_t              head;
  logic [X_BITS-1:0] raw_x;
  logic [Y_BITS-1:0] raw_y;
  logic              attempt;
  logic              push;
  logic              drop;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [15:0]       gen_next;
  logic              limit_hit;
  logic              unused_rand;

  assign unused_rand = ^rand_vect;

  // Self-addressed draws are redirected one column over rather than discarded.
  assign raw_x       = rand_vect[8 +: X_BITS];
  assign raw_y       = rand_vect[12 +: Y_BITS];
  assign cand.dest_x = (raw_x == SELF_X && raw_y == SELF_Y) ? ALT_X : raw_x;
  assign cand.dest_y = raw_y;
  assign cand.seq    = seq;
  assign cand.data   = rand_vect[16 +: DATA_WIDTH];

  assign attempt   = (state == S_RUN) && (rand_vect[7:0] < inj_rate);
  assign push      = attempt && !fifo_full;
  assign drop      = attempt && fifo_full;
  assign pop       = out_valid && out_ready;
  assign gen_next  = (push && gen_cnt != 16'hFFFF) ? gen_cnt + 16'd1 : gen_cnt;
  assign limit_hit = (pkt_limit != 16'd0) && (gen_next >= pkt_limit);

  sync_fifo #(
    .W     ($bits(pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (cand),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          next_state = S_RUN;
          start_run  = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable)        next_state = S_IDLE;
        else if (limit_hit) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (!enable)         next_state = S_IDLE;
        else if (fifo_empty) next_state = S_DONE;
      end
      S_DONE: begin
        if (!enable) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      gen_cnt  <= '0;
      drop_cnt <= '0;
      seq      <= '0;
    end else begin
      state <= next_state;
      if (start_run) begin
        gen_cnt  <= '0;
        drop_cnt <= '0;
        seq      <= '0;
      end else begin
        gen_cnt <= gen_next;
        if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        if (push) seq <= seq + 8'd1;
      end
    end
  end

  // Fields are masked while empty so an idle port never shows stale queue contents.
  assign out_valid  = !fifo_empty;
  assign out_dest_x = out_valid ? head.dest_x : '0;
  assign out_dest_y = out_valid ? head.dest_y : '0;
  assign out_seq    = out_valid ? head.seq    : '0;
  assign out_data   = out_valid ? head.data   : '0;
  assign done       = (state == S_DONE);
endmodule

// File: tb/tb_grid_traffic_gen.sv
// Randomized bench for grid_traffic_gen: two nodes (1,2) and (3,1) share stimulus and are scored
// against a queue-based reference model, plus directed checks for the main scenarios.
module tb_grid_traffic_gen;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rand_vect;
  logic        enable;
  logic [7:0]  inj_rate;
  logic [15:0] pkt_limit;
  logic        out_ready;
  logic        out_valid [2];
  logic [1:0]  out_dest_x [2];
  logic [1:0]  out_dest_y [2];
  logic [7:0]  out_seq [2];
  logic [15:0] out_data [2];
  logic [15:0] gen_cnt [2];
  logic [15:0] drop_cnt [2];
  logic        done [2];

  always #5 clk = ~clk;

  grid_traffic_gen #(.MY_X(1), .MY_Y(2)) u_node0 (
    .clk(clk), .reset_n(reset_n), .rand_vect(rand_vect), .enable(enable),
    .inj_rate(inj_rate), .pkt_limit(pkt_limit), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_dest_x(out_dest_x[0]), .out_dest_y(out_dest_y[0]),
    .out_seq(out_seq[0]), .out_data(out_data[0]), .gen_cnt(gen_cnt[0]),
    .drop_cnt(drop_cnt[0]), .done(done[0])
  );

  grid_traffic_gen #(.MY_X(3), .MY_Y(1)) u_node1 (
    .clk(clk), .reset_n(reset_n), .rand_vect(rand_vect), .enable(enable),
    .inj_rate(inj_rate), .pkt_limit(pkt_limit), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_dest_x(out_dest_x[1]), .out_dest_y(out_dest_y[1]),
    .out_seq(out_seq[1]), .out_data(out_data[1]), .gen_cnt(gen_cnt[1]),
    .drop_cnt(drop_cnt[1]), .done(done[1])
  );

  typedef struct packed {
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic [7:0]  seq;
    logic [15:0] data;
  } pkt_t;

  pkt_t       mq [2][$];
  int         m_st [2];
  int         m_gen [2];
  int         m_drop [2];
  int         m_seq [2];
  int         node_x [2] = '{1, 3};
  int         node_y [2] = '{2, 1};
  logic [7:0] obs_log [2][$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      m_st[d] = M_IDLE;
      m_gen[d] = 0;
      m_drop[d] = 0;
      m_seq[d] = 0;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs currently driven.
  task automatic model_step(input int d);
    int   pre;
    pkt_t p;
    pre = mq[d].size();
    if (pre > 0 && out_ready) void'(mq[d].pop_front());
    case (m_st[d])
      M_IDLE: if (enable) begin
        m_gen[d] = 0; m_drop[d] = 0; m_seq[d] = 0; m_st[d] = M_RUN;
      end
      M_RUN: begin
        if (rand_vect[7:0] < inj_rate) begin
          if (pre == DEPTH) begin
            if (m_drop[d] < 65535) m_drop[d]++;
          end else begin
            p.dx = rand_vect[9:8];
            p.dy = rand_vect[13:12];
            if (p.dx == node_x[d] && p.dy == node_y[d]) p.dx = 2'((node_x[d] + 1) % 4);
            p.seq = 8'(m_seq[d]);
            p.data = rand_vect[31:16];
            mq[d].push_back(p);
            m_seq[d] = (m_seq[d] + 1) % 256;
            if (m_gen[d] < 65535) m_gen[d]++;
          end
        end
        if (!enable) m_st[d] = M_IDLE;
        else if (pkt_limit != 0 && m_gen[d] >= pkt_limit) m_st[d] = M_DRAIN;
      end
      M_DRAIN: begin
        if (!enable) m_st[d] = M_IDLE;
        else if (pre == 0) m_st[d] = M_DONE;
      end
      default: if (!enable) m_st[d] = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("n%0d_valid", d), 32'(out_valid[d]), 32'(mq[d].size() > 0));
      if (mq[d].size() > 0) begin
        check_eq($sformatf("n%0d_dest_x", d), 32'(out_dest_x[d]), 32'(mq[d][0].dx));
        check_eq($sformatf("n%0d_dest_y", d), 32'(out_dest_y[d]), 32'(mq[d][0].dy));
        check_eq($sformatf("n%0d_seq", d), 32'(out_seq[d]), 32'(mq[d][0].seq));
        check_eq($sformatf("n%0d_data", d), 32'(out_data[d]), 32'(mq[d][0].data));
      end
      check_eq($sformatf("n%0d_gen_cnt", d), 32'(gen_cnt[d]), 32'(m_gen[d]));
      check_eq($sformatf("n%0d_drop_cnt", d), 32'(drop_cnt[d]), 32'(m_drop[d]));
      check_eq($sformatf("n%0d_done", d), 32'(done[d]), 32'(m_st[d] == M_DONE));
    end
  endtask

  task automatic cyc(input logic e, input logic [7:0] rate, input logic [15:0] lim,
                     input logic rdy, input logic [31:0] r);
    @(negedge clk);
    enable = e; inj_rate = rate; pkt_limit = lim; out_ready = rdy; rand_vect = r;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (out_valid[d] && out_ready) obs_log[d].push_back(out_seq[d]);
      model_step(d);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rv_lo0();
    logic [31:0] v;
    v = $urandom();
    return {v[31:8], 8'h00};
  endfunction

  task automatic clear_logs();
    obs_log[0].delete();
    obs_log[1].delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] first_data;
    logic        seen_valid;
    logic        e;
    logic [15:0] lim;
    logic [7:0]  rate;
    int          rdy_pct;

    reset_n = 1'b0; enable = 1'b0; inj_rate = 8'd0; pkt_limit = 16'd0;
    out_ready = 1'b1; rand_vect = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rst_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_gen", 32'(gen_cnt[0]), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt[0]), 32'd0);
    check_eq("rst_done", 32'(done[0]), 32'd0);
    check_eq("rst_data", 32'(out_data[0]), 32'd0);
    compare_all();
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 8'd255, 16'd0, 1'b1, $urandom());
      seen_valid |= out_valid[0] | out_valid[1];
    end
    check_eq("rst_quiet", 32'(seen_valid), 32'd0);

    // Limited run of three packets, then drain and done.
    clear_logs();
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'd255, 16'd3, 1'b1, rv_lo0());
    check_eq("lim_gen", 32'(gen_cnt[0]), 32'd3);
    check_eq("lim_done", 32'(done[0]), 32'd1);
    check_eq("lim_valid", 32'(out_valid[0]), 32'd0);
    check_eq("lim_npkts", obs_log[0].size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < obs_log[0].size()) check_eq($sformatf("lim_seq%0d", i), 32'(obs_log[0][i]), i);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 16'd0, 1'b1, $urandom());
    check_eq("dis_done", 32'(done[0]), 32'd0);

    // Self-addressed draws.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd255, 16'd0, 1'b1, {16'hA5A5, 4'h2, 4'h1, 8'h00});
    check_eq("self0_x", 32'(out_dest_x[0]), 32'd2);
    check_eq("self0_y", 32'(out_dest_y[0]), 32'd2);
    check_eq("self0_data", 32'(out_data[0]), 32'hA5A5);
    for (int i = 0; i < 2; i++) cyc(1'b1, 8'd255, 16'd0, 1'b1, {16'h5A5A, 4'h1, 4'h3, 8'h00});
    check_eq("self1_x", 32'(out_dest_x[1]), 32'd0);
    check_eq("self1_y", 32'(out_dest_y[1]), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'd0, 16'd0, 1'b1, $urandom());

    // Backpressure: ten attempts into a four-entry queue.
    clear_logs();
    first_data = 16'd0;
    for (int i = 0; i < 11; i++) begin
      logic [31:0] r;
      r = rv_lo0();
      if (i == 1) first_data = r[31:16];
      cyc(1'b1, 8'd255, 16'd0, 1'b0, r);
      if (i >= 1) begin
        check_eq("bp_head_seq", 32'(out_seq[0]), 32'd0);
        check_eq("bp_head_data", 32'(out_data[0]), 32'(first_data));
      end
    end
    check_eq("bp_gen", 32'(gen_cnt[0]), 32'd4);
    check_eq("bp_drop", 32'(drop_cnt[0]), 32'd6);
    cyc(1'b1, 8'd255, 16'd0, 1'b1, rv_lo0());
    check_eq("fullpop_drop", 32'(drop_cnt[0]), 32'd7);
    check_eq("fullpop_head", 32'(out_seq[0]), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'd0, 16'd0, 1'b1, $urandom());
    check_eq("bp_npkts", obs_log[0].size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs_log[0].size()) check_eq($sformatf("bp_seq%0d", i), 32'(obs_log[0][i]), i);

    // Zero injection rate, then disable with two packets queued.
    seen_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 8'd0, 16'd0, 1'($urandom_range(0, 1)), $urandom());
      seen_valid |= out_valid[0] | out_valid[1];
    end
    check_eq("zr_gen", 32'(gen_cnt[0]), 32'd0);
    check_eq("zr_drop", 32'(drop_cnt[0]), 32'd0);
    check_eq("zr_valid", 32'(seen_valid), 32'd0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 8'd255, 16'd0, 1'b0, rv_lo0());
    clear_logs();
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 16'd0, 1'b1, $urandom());
    check_eq("dq_npkts", obs_log[0].size(), 32'd2);
    for (int i = 0; i < 2; i++)
      if (i < obs_log[0].size()) check_eq($sformatf("dq_seq%0d", i), 32'(obs_log[0][i]), i);
    check_eq("dq_valid", 32'(out_valid[0]), 32'd0);

    // Random traffic.
    e = 1'b0; lim = 16'd0; rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 47) == 0) begin
        e = !e;
        lim = 16'($urandom_range(0, 6));
        case ($urandom_range(0, 2))
          0: rdy_pct = 10;
          1: rdy_pct = 50;
          default: rdy_pct = 90;
        endcase
      end
      case ($urandom_range(0, 3))
        0: rate = 8'd0;
        1: rate = 8'($urandom_range(0, 255));
        default: rate = 8'd200;
      endcase
      cyc(e, rate, lim, 1'($urandom_range(0, 99) < rdy_pct), $urandom());
    end

    // Reset while packets are queued.
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 16'd0, 1'b1, $urandom());
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd255, 16'd0, 1'b0, rv_lo0());
    check_eq("mr_pre_valid", 32'(out_valid[0]), 32'd1);
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("mr_valid0", 32'(out_valid[0]), 32'd0);
    check_eq("mr_valid1", 32'(out_valid[1]), 32'd0);
    check_eq("mr_gen", 32'(gen_cnt[0]), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 16'd0, 1'b1, $urandom());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
